// File: rtl/wb_bus_if_if.sv
// Signal bundle between one CPU memory port, the pipeline controller and a Wishbone B3 classic slave.
// The master modport is the bridge's view; slave is the view of everything around it.
interface wb_bus_if_if;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        bus_err_o;

    modport master (
        input  stall_i, flush_i, cpu_ce_i, cpu_addr_i, cpu_data_i, cpu_we_i, cpu_sel_i,
        input  wb_dat_i, wb_ack_i,
        output cpu_data_o, stallreq,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, bus_err_o
    );

    modport slave (
        output stall_i, flush_i, cpu_ce_i, cpu_addr_i, cpu_data_i, cpu_we_i, cpu_sel_i,
        output wb_dat_i, wb_ack_i,
        input  cpu_data_o, stallreq,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, bus_err_o
    );
endinterface

// File: rtl/wb_bus_if.sv
// Single-cycle CPU memory port to Wishbone B3 classic master bridge, one instance per core port.
// Optional BUSY watchdog enabled by defining WB_TIMEOUT_EN.
//
//   state          | meaning
//   IDLE           | no cycle on the bus; a new CPU request is accepted here
//   BUSY           | stb/cyc asserted, waiting for ack (pipeline held via stallreq)
//   WAIT_FOR_STALL | ack seen but stage still frozen; rd_buf replayed to the CPU
module wb_bus_if #(
    parameter int unsigned STALL_BIT      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    wb_bus_if_if.master   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_we;
    logic [3:0]  r_sel;
    logic        r_stb;
    logic [31:0] r_rd_buf;

    logic        w_stall_me;
    logic        w_start;
    logic        w_abort;
    logic        w_ack;
    logic        w_timeout;
    logic        w_unused_stall;

    assign w_stall_me     = bus.stall_i[STALL_BIT];
    assign w_unused_stall = ^bus.stall_i;

    assign w_start = (r_state == IDLE) && bus.cpu_ce_i && !bus.flush_i;
    assign w_abort = (r_state == BUSY) && bus.flush_i;
    assign w_ack   = (r_state == BUSY) && !bus.flush_i && bus.wb_ack_i;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WDOG_W-1:0] r_wdog;
    logic              r_bus_err;

    // Ack in the same cycle wins, so the timeout only fires when ack is absent.
    assign w_timeout = (r_state == BUSY) && !bus.flush_i && !bus.wb_ack_i &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_start)
                r_wdog <= '0;
            else if (r_state == BUSY)
                r_wdog <= r_wdog + 1'b1;
        end
    end

    assign bus.bus_err_o = r_bus_err;
`else
    logic w_unused_cfg;

    assign w_timeout     = 1'b0;
    assign w_unused_cfg  = TIMEOUT_CYCLES[0];
    assign bus.bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.stallreq   = 1'b0;
        bus.cpu_data_o = '0;
        case (r_state)
            IDLE: begin
                bus.stallreq = bus.cpu_ce_i && !bus.flush_i;
                if (w_start)
                    w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_abort || w_timeout) begin
                    w_state_nxt = IDLE;
                end else if (w_ack) begin
                    bus.cpu_data_o = r_we ? 32'h0 : bus.wb_dat_i;
                    w_state_nxt    = w_stall_me ? WAIT_FOR_STALL : IDLE;
                end else begin
                    bus.stallreq = 1'b1;
                end
            end
            WAIT_FOR_STALL: begin
                bus.cpu_data_o = r_rd_buf;
                if (!w_stall_me || bus.flush_i)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adr    <= '0;
            r_dat    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_stb    <= 1'b0;
            r_rd_buf <= '0;
        end else if (w_start) begin
            r_adr    <= bus.cpu_addr_i;
            r_dat    <= bus.cpu_data_i;
            r_we     <= bus.cpu_we_i;
            r_sel    <= bus.cpu_sel_i;
            r_stb    <= 1'b1;
            r_rd_buf <= '0;
        end else if (w_ack || w_abort || w_timeout) begin
            r_adr <= '0;
            r_dat <= '0;
            r_we  <= 1'b0;
            r_sel <= '0;
            r_stb <= 1'b0;
            if (w_ack && !r_we)
                r_rd_buf <= bus.wb_dat_i;
        end
    end

    assign bus.wb_adr_o = r_adr;
    assign bus.wb_dat_o = r_dat;
    assign bus.wb_we_o  = r_we;
    assign bus.wb_sel_o = r_sel;
    assign bus.wb_stb_o = r_stb;
    assign bus.wb_cyc_o = r_stb;
endmodule
